// File: rtl/ps2_key_test_pkg.sv
// Shared types and helpers for the PS/2 keyboard-to-UART hex echo block.
package ps2_key_test_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_DONE  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Uppercase ASCII hex digit for a nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/ps2_key_test_ps2_rx.sv
// PS/2 frame receiver: synchronizers, clock glitch filter and frame FSM.
module ps2_rx
    import ps2_key_test_pkg::*;
#(
    parameter int unsigned FILTER_STEPS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       rx_done,
    output logic [7:0] dout,
    output logic       parity
);

    localparam int unsigned FILT_W = $clog2(FILTER_STEPS + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_STEPS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic              r_filt;
    logic [FILT_W-1:0] r_filt_cnt;
    rx_state_t         r_state;
    rx_state_t         w_state_next;
    logic [3:0]        r_bit_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic              w_clk_s;
    logic              w_data_s;
    logic              w_fall;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    // Falling edge is the cycle the filter commits a high-to-low change.
    assign w_fall   = r_filt && !w_clk_s && (r_filt_cnt == FILT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt     <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FILT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (w_fall && !w_data_s) begin
                    w_state_next = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (w_fall && (r_bit_cnt == 4'd9)) begin
                    w_state_next = w_data_s ? RX_DONE : RX_IDLE;
                end else if (!w_fall && (r_to_cnt == TO_LAST)) begin
                    w_state_next = RX_IDLE;
                end
            end
            RX_DONE: w_state_next = RX_IDLE;
            default: w_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done = (r_state == RX_DONE);
    end

    // Bits 0-7 data, 8 parity, 9 stop; the start bit is consumed in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (r_state != RX_SHIFT) begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
        end else if (w_fall) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt < 4'd8) begin
                r_shift <= {w_data_s, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd8) begin
                r_parity <= w_data_s;
            end
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign dout   = r_shift;
    assign parity = r_parity;

endmodule

// File: rtl/ps2_key_test.sv
// PS/2 key test: shows the last scan code / count on LEDs and echoes codes as hex over UART.
module ps2_key_test
    import ps2_key_test_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned FILTER_STEPS   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic [4:0] BTN,
    input  logic [7:0] SW,
    input  logic       UART_RXD,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] LED,
    output logic       UART_TXD
);

    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int unsigned BAUD_W     = $clog2(BIT_CYCLES);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);

    logic              w_rst;
    logic              w_rx_done;
    logic [7:0]        w_rx_byte;
    logic              w_parity;
    logic              w_unused;
    logic [7:0]        r_last_code;
    logic [7:0]        r_rx_count;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    tx_state_t         r_tx_state;
    tx_state_t         w_tx_state_next;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [1:0]        r_char_idx;
    logic [7:0]        r_tx_byte;
    logic [7:0]        w_char;
    logic              w_tick;
    logic              w_tx_bit;
    logic              r_txd;

    assign w_rst    = BTN[0];
    assign w_unused = ^{BTN[4:1], SW[7:1], UART_RXD, w_parity};

    ps2_rx #(
        .FILTER_STEPS  (FILTER_STEPS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ps2_rx (
        .i_clk     (CLK),
        .i_rst     (w_rst),
        .i_ps2_clk (ps2_clk),
        .i_ps2_data(ps2_data),
        .rx_done   (w_rx_done),
        .dout      (w_rx_byte),
        .parity    (w_parity)
    );

    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_last_code <= '0;
            r_rx_count  <= '0;
        end else if (w_rx_done) begin
            r_last_code <= w_rx_byte;
            r_rx_count  <= r_rx_count + 8'd1;
        end
    end

    assign LED = SW[0] ? r_last_code : r_rx_count;

    // Scan-code FIFO; a full FIFO still accepts a byte if it is popped the same cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = w_rx_done && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_rx_byte;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    assign w_tick = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        case (r_char_idx)
            2'd0:    w_char = hex_ascii(r_tx_byte[7:4]);
            2'd1:    w_char = hex_ascii(r_tx_byte[3:0]);
            default: w_char = SPACE_CHAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (!w_empty) w_tx_state_next = TX_START;
            TX_START: if (w_tick) w_tx_state_next = TX_DATA;
            TX_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_tx_state_next = TX_STOP;
            TX_STOP: begin
                if (w_tick) begin
                    w_tx_state_next = (r_char_idx == 2'd2) ? TX_IDLE : TX_START;
                end
            end
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_pop    = 1'b0;
        w_tx_bit = 1'b1;
        case (r_tx_state)
            TX_IDLE:  w_pop    = !w_empty;
            TX_START: w_tx_bit = 1'b0;
            TX_DATA:  w_tx_bit = w_char[r_bit_idx];
            default:  w_tx_bit = 1'b1;
        endcase
    end

    // Baud/bit/character counters; a pop restarts the three-character sequence.
    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_char_idx <= '0;
            r_tx_byte  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= w_tx_bit;
            if (w_pop) begin
                r_tx_byte  <= r_mem[r_rd_ptr[PTR_W-1:0]];
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
                r_char_idx <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tick) begin
                    r_baud_cnt <= '0;
                    if (r_tx_state == TX_DATA) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    if (r_tx_state == TX_STOP) begin
                        r_char_idx <= r_char_idx + 2'd1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                end
            end
        end
    end

    assign UART_TXD = r_txd;

endmodule

// File: tb/tb_ps2_key_test.sv
// Directed + randomized bench for ps2_key_test with a UART decoder and reference model.
module tb_ps2_key_test;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int unsigned BIT      = CLK_FREQ / BAUD;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TIMEOUT  = 500;

    logic       CLK = 1'b0;
    logic [4:0] BTN = 5'b00001;
    logic [7:0] SW = 8'h01;
    logic       UART_RXD = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] LED;
    logic       UART_TXD;

    int         checks = 0;
    int         failures = 0;
    int         framing_err = 0;
    bit         mon_en = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_chars[$];
    logic [7:0] exp_last = 8'h00;
    logic [7:0] exp_count = 8'h00;
    string      HEX = "0123456789ABCDEF";

    ps2_key_test #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .FILTER_STEPS  (2),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .CLK     (CLK),
        .BTN     (BTN),
        .SW      (SW),
        .UART_RXD(UART_RXD),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .LED     (LED),
        .UART_TXD(UART_TXD)
    );

    always #5 CLK = ~CLK;

    // UART 8N1 decoder sampling mid-bit.
    initial begin
        logic [7:0] ch;
        wait (mon_en);
        forever begin
            @(negedge UART_TXD);
            repeat (BIT / 2) @(negedge CLK);
            if (UART_TXD !== 1'b0) framing_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge CLK);
                ch[i] = UART_TXD;
            end
            repeat (BIT) @(negedge CLK);
            if (UART_TXD !== 1'b1) framing_err++;
            got.push_back(ch);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: an accepted byte echoes as two uppercase hex digits and a space.
    task automatic expect_echo(input logic [7:0] b);
        exp_chars.push_back(8'(HEX[int'(b[7:4])]));
        exp_chars.push_back(8'(HEX[int'(b[3:0])]));
        exp_chars.push_back(8'h20);
    endtask

    task automatic model_rx(input logic [7:0] b);
        exp_last  = b;
        exp_count = exp_count + 8'd1;
    endtask

    task automatic ps2_send(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLK);
            ps2_data = fr[i];
            repeat (4) @(negedge CLK);
            if (glitch && (i == 5)) begin
                ps2_clk = 1'b0;
                @(negedge CLK);
                ps2_clk = 1'b1;
                repeat (4) @(negedge CLK);
            end
            ps2_clk = 1'b0;
            repeat (10) @(negedge CLK);
            ps2_clk = 1'b1;
            repeat (5) @(negedge CLK);
        end
        ps2_data = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic check_led(input string tag);
        SW[0] = 1'b1;
        #1;
        check({tag, "_code"}, 32'(LED), 32'(exp_last));
        SW[0] = 1'b0;
        #1;
        check({tag, "_count"}, 32'(LED), 32'(exp_count));
        SW[0] = 1'b1;
    endtask

    task automatic compare_uart(input string tag);
        int budget;
        budget = exp_chars.size() * 10 * BIT + 2000;
        while ((got.size() < exp_chars.size()) && (budget > 0)) begin
            @(negedge CLK);
            budget--;
        end
        check({tag, "_len"}, 32'(got.size()), 32'(exp_chars.size()));
        while ((exp_chars.size() > 0) && (got.size() > 0)) begin
            check(tag, 32'(got.pop_front()), 32'(exp_chars.pop_front()));
        end
        exp_chars.delete();
        got.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] burst[6];

        // Reset state
        repeat (5) @(negedge CLK);
        check("rst_led", 32'(LED), 32'h00);
        check("rst_txd", 32'(UART_TXD), 32'h1);
        BTN[0] = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge CLK);
        check_led("after_rst");

        // Single 0x1C, then 0xF0 and 0x1C spaced 200 cycles
        ps2_send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        model_rx(8'h1C); expect_echo(8'h1C);
        check_led("one_1c");
        repeat (200) @(negedge CLK);
        ps2_send(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        model_rx(8'hF0); expect_echo(8'hF0);
        repeat (200) @(negedge CLK);
        ps2_send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        model_rx(8'h1C); expect_echo(8'h1C);
        check_led("seq3");
        compare_uart("uart_seq3");

        // Stop bit 0 discards the frame
        ps2_send(8'($urandom), 1'b0, 1'b0, 11, 1'b0);
        repeat (500) @(negedge CLK);
        check_led("bad_stop");
        check("bad_stop_uart", 32'(got.size()), 32'h0);

        // Idle glitch that looks like a start bit
        @(negedge CLK);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        @(negedge CLK);
        ps2_clk  = 1'b1;
        repeat (3) @(negedge CLK);
        ps2_data = 1'b1;
        repeat (20) @(negedge CLK);

        // Random bytes, random parity, mid-frame glitches on alternate frames
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            ps2_send(b, 1'($urandom), 1'b1, 11, k[0]);
            model_rx(b); expect_echo(b);
            check_led("rand");
        end
        compare_uart("uart_rand");

        // Partial frame abandoned by timeout, then a clean frame
        ps2_send(8'($urandom), 1'b0, 1'b1, 4, 1'b0);
        repeat (TIMEOUT + 100) @(negedge CLK);
        check_led("timeout_idle");
        b = 8'($urandom);
        ps2_send(b, 1'b1, 1'b1, 11, 1'b0);
        model_rx(b); expect_echo(b);
        check_led("after_timeout");
        compare_uart("uart_timeout");

        // Reset after the 5th bit, then 0x5A
        ps2_send(8'($urandom), 1'b0, 1'b1, 5, 1'b0);
        BTN[0] = 1'b1;
        exp_last = 8'h00; exp_count = 8'h00;
        repeat (3) @(negedge CLK);
        check_led("in_reset");
        check("in_reset_txd", 32'(UART_TXD), 32'h1);
        BTN[0] = 1'b0;
        repeat (5) @(negedge CLK);
        ps2_send(8'h5A, 1'b1, 1'b1, 11, 1'b0);
        model_rx(8'h5A); expect_echo(8'h5A);
        check_led("post_reset");
        compare_uart("uart_5a");

        // Burst of 6: first goes straight to the UART, DEPTH queue, rest dropped
        for (int k = 0; k < 6; k++) begin
            burst[k] = 8'($urandom);
            ps2_send(burst[k], 1'($urandom), 1'b1, 11, 1'b0);
            model_rx(burst[k]);
            if (k < 1 + DEPTH) expect_echo(burst[k]);
        end
        check_led("burst");
        compare_uart("uart_burst");

        repeat (500) @(negedge CLK);
        check("no_extra_chars", 32'(got.size()), 32'h0);
        check("framing", 32'(framing_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
